// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - FSM encoding, Rcon constants and xtime helper for the AES round sequencer
package aes_pkg;

   localparam logic [7:0] RCON_INIT = 8'h01;
   localparam logic [7:0] AES_POLY  = 8'h1B;

   localparam int NR_128 = 10;
   localparam int NR_192 = 12;
   localparam int NR_256 = 14;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } aes_state_e;

   // Multiply by x in GF(2^8) modulo the Rijndael polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// rtl/aes_rcon_gen.sv - Rcon register: load restarts the sequence, adv steps it by xtime
module aes_rcon_gen
   import aes_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       adv,
   output logic [7:0] rcon
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rcon <= RCON_INIT;
      end else if (load) begin
         rcon <= RCON_INIT;
      end else if (adv) begin
         rcon <= xtime(rcon);
      end
   end

endmodule

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - iterative AES round sequencer driving state/key register enables
// Optional AES_ABORT_EN adds an abort input that drops an in-flight block.
module aes_round_ctrl
   import aes_pkg::*;
#(
   parameter int NR = NR_128,
   parameter int RW = 4
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          out_valid,
   input  logic          out_ready,
`ifdef AES_ABORT_EN
   input  logic          abort,
`endif
   output logic          state_en,
   output logic          key_en,
   output logic          sel_init,
   output logic          last_round,
   output logic [RW-1:0] round,
   output logic [7:0]    rcon,
   output logic          busy
);

   localparam logic [RW-1:0] ROUND_LAST = RW'(NR);

   aes_state_e state, state_nxt;
   logic       abort_act;
   logic       accept;
   logic       at_last;
   logic       leave_done;
   logic       rcon_load;
   logic       rcon_adv;

`ifdef AES_ABORT_EN
   assign abort_act = abort && (state != IDLE);
`else
   assign abort_act = 1'b0;
`endif

   assign accept     = (state == IDLE) && in_valid;
   assign at_last    = (state == ROUND) && (round == ROUND_LAST);
   assign leave_done = (state == DONE) && out_ready;

   always_comb begin
      state_nxt = state;
      if (abort_act) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (in_valid)  state_nxt = ROUND;
            ROUND:   if (at_last)   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // round holds NR through DONE so the consumer still sees the final round number.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         round <= '0;
      end else if (abort_act || leave_done) begin
         round <= '0;
      end else if (accept) begin
         round <= RW'(1);
      end else if ((state == ROUND) && !at_last) begin
         round <= round + RW'(1);
      end
   end

   assign rcon_load = accept || leave_done || abort_act;
   assign rcon_adv  = (state == ROUND) && !at_last && !abort_act;

   aes_rcon_gen u_rcon (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (rcon_load),
      .adv   (rcon_adv),
      .rcon  (rcon)
   );

   assign in_ready   = (state == IDLE);
   assign out_valid  = (state == DONE) && !abort_act;
   assign state_en   = accept || ((state == ROUND) && !abort_act);
   assign key_en     = state_en;
   assign sel_init   = accept;
   assign last_round = at_last;
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - vector table, corner sequences and randomized model check of aes_round_ctrl
// Abort checks are compiled in when AES_ABORT_EN is defined.
module tb_aes_round_ctrl;

   localparam int NR = 10;
   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic       in_ready, out_valid, state_en, key_en, sel_init, last_round, busy;
   logic [3:0] round;
   logic [7:0] rcon;
`ifdef AES_ABORT_EN
   logic       abort = 1'b0;
   logic       ab14 = 1'b0;
`endif

   logic       iv14 = 1'b0;
   logic       or14 = 1'b1;
   logic       ir14, ov14, se14, ke14, si14, lr14, bz14;
   logic [3:0] rd14;
   logic [7:0] rc14;

   aes_round_ctrl #(.NR(NR), .RW(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
`ifdef AES_ABORT_EN
      .abort      (abort),
`endif
      .state_en   (state_en),
      .key_en     (key_en),
      .sel_init   (sel_init),
      .last_round (last_round),
      .round      (round),
      .rcon       (rcon),
      .busy       (busy)
   );

   aes_round_ctrl #(.NR(14), .RW(4)) dut14 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (iv14),
      .in_ready   (ir14),
      .out_valid  (ov14),
      .out_ready  (or14),
`ifdef AES_ABORT_EN
      .abort      (ab14),
`endif
      .state_en   (se14),
      .key_en     (ke14),
      .sel_init   (si14),
      .last_round (lr14),
      .round      (rd14),
      .rcon       (rc14),
      .busy       (bz14)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural AES-128 datapath driven by the DUT's controls
   logic [7:0] sbox [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00, aa = a, bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
   endfunction

   function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] t, n0, n1, n2, n3;
      t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
      n0 = k[127:96] ^ t;
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = k[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
      logic [7:0] b [16];
      logic [7:0] c [16];
      logic [7:0] a0, a1, a2, a3;
      logic [127:0] r;
      for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
      for (int i = 0; i < 16; i++) c[i] = b[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
      if (!last) begin
         for (int col = 0; col < 4; col++) begin
            a0 = c[4*col]; a1 = c[4*col+1]; a2 = c[4*col+2]; a3 = c[4*col+3];
            c[4*col]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            c[4*col+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            c[4*col+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            c[4*col+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
         end
      end
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = c[i];
      return r ^ rk;
   endfunction

   logic [127:0] pt = '0, key = '0, st = '0, kr = '0, nk;
   assign nk = next_key(kr, rcon);

   always @(posedge clk) begin
      if (state_en) st <= sel_init ? (pt ^ key) : round_fn(st, nk, last_round);
      if (key_en)   kr <= sel_init ? key : nk;
   end

   // ---------------- helpers
   function automatic logic [18:0] pack(input logic ir, input logic ov, input logic en,
                                        input logic sel, input logic last, input logic bz,
                                        input logic [3:0] rnd, input logic [7:0] rc);
      return {ir, ov, en, en, sel, last, bz, rnd, rc};
   endfunction

   function automatic logic [18:0] dut_vec();
      return {in_ready, out_valid, state_en, key_en, sel_init, last_round, busy, round, rcon};
   endfunction

   localparam logic [18:0] RST_V = {1'b1, 6'b000000, 4'd0, 8'h01};

   typedef struct {
      logic        iv;
      logic        ordy;
      logic [18:0] exp;
      logic        chk_rc;
   } vec_t;

   vec_t       tv [15];
   logic [7:0] rc10 [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
   logic [7:0] rc14t [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36,
                              8'h6c, 8'hd8, 8'hab, 8'h4d};
   logic [7:0] rc_pow [16];

   // reference model state: block in flight, cycles since accept, Rcon known in IDLE
   bit m_busy;
   int m_cnt;
   bit m_rc_known;

   task automatic start_and_wait(input logic keep_valid, output int lat);
      lat = -1;
      @(negedge clk);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      #1;
      chk("accept_sel_init", 128'(sel_init), 128'(1));
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         in_valid = keep_valid;
         #1;
         if (out_valid) begin
            lat = k - 1;
            break;
         end
      end
   endtask

   initial begin
      int  lat;
      bit  found;
      logic [7:0] p;

      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv;
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
      p = 8'h01;
      for (int i = 0; i < 16; i++) begin
         rc_pow[i] = p;
         p = gmul(p, 8'h02);
      end

      tv[0] = '{1'b0, 1'b1, RST_V, 1'b1};
      tv[1] = '{1'b1, 1'b0, pack(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'h01), 1'b1};
      for (int r = 1; r <= 10; r++)
         tv[r+1] = '{((r + 1) % 3 == 0), 1'b1,
                     pack(1'b0, 1'b0, 1'b1, 1'b0, (r == 10), 1'b1, 4'(r), rc10[r-1]), 1'b1};
      tv[12] = '{1'b0, 1'b0, pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd10, 8'h36), 1'b1};
      tv[13] = '{1'b1, 1'b1, pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd10, 8'h36), 1'b1};
      tv[14] = '{1'b0, 1'b0, RST_V, 1'b0};

      // reset asserted, then released
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("reset_vec", 128'(dut_vec()), 128'(RST_V));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_reset_vec", 128'(dut_vec()), 128'(RST_V));

      // one block through the vector table, FIPS-197 C.1 data
      pt  = FIPS_PT;
      key = FIPS_KEY;
      for (int i = 0; i < 15; i++) begin
         logic [18:0] msk;
         @(negedge clk);
         in_valid  = tv[i].iv;
         out_ready = tv[i].ordy;
         #1;
         msk = tv[i].chk_rc ? '1 : ~19'h000ff;
         chk($sformatf("vec%0d", i), 128'(dut_vec() & msk), 128'(tv[i].exp & msk));
         if (i == 12) chk("fips_ct", st, FIPS_CT);
      end

      // DONE stall with in_valid held high, then the queued block is accepted
      start_and_wait(1'b1, lat);
      chk("latency_hold", 128'(lat), 128'(NR));
      for (int h = 0; h < 5; h++) begin
         @(negedge clk);
         in_valid  = 1'b1;
         out_ready = 1'b0;
         #1;
         chk("hold_out_valid", 128'({out_valid, in_ready, sel_init}), 128'(3'b100));
         chk("hold_ct", st, FIPS_CT);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      chk("release_out_valid", 128'(out_valid), 128'(1));
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      chk("queued_accept", 128'({in_ready, sel_init, busy}), 128'(3'b110));
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("queued_round1", 128'({busy, round}), 128'({1'b1, 4'd1}));

      // asynchronous reset at round 5
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         if (round == 4'd5) found = 1'b1;
         else begin
            @(negedge clk);
            #1;
         end
      end
      chk("reach_round5", 128'(found), 128'(1));
      rst_n = 1'b0;
      #1;
      chk("midrun_reset_vec", 128'(dut_vec()), 128'(RST_V));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midrun_release_vec", 128'(dut_vec()), 128'(RST_V));
      start_and_wait(1'b0, lat);
      chk("latency_after_reset", 128'(lat), 128'(NR));
      chk("ct_after_reset", st, FIPS_CT);
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

`ifdef AES_ABORT_EN
      // abort at round 3, and abort ignored in IDLE
      @(negedge clk);
      in_valid = 1'b1;
      abort    = 1'b1;
      #1;
      chk("abort_idle_accept", 128'(sel_init), 128'(1));
      @(negedge clk);
      in_valid = 1'b0;
      abort    = 1'b0;
      for (int k = 0; k < 20 && round != 4'd3; k++) begin
         @(negedge clk);
         #1;
      end
      abort = 1'b1;
      #1;
      chk("abort_enables", 128'({round, state_en, key_en, out_valid}), 128'({4'd3, 3'b000}));
      @(negedge clk);
      abort = 1'b0;
      #1;
      chk("abort_idle_vec", 128'(dut_vec()), 128'(RST_V));
`endif

      // NR = 14 Rcon sequence
      @(negedge clk);
      iv14 = 1'b1;
      #1;
      chk("nr14_accept", 128'(si14), 128'(1));
      for (int r = 1; r <= 14; r++) begin
         @(negedge clk);
         iv14 = 1'b0;
         #1;
         chk($sformatf("nr14_r%0d", r), 128'({rd14, rc14, lr14, se14}),
             128'({4'(r), rc14t[r-1], (r == 14), 1'b1}));
      end
      @(negedge clk);
      #1;
      chk("nr14_done", 128'({ov14, se14}), 128'(2'b10));
      @(negedge clk);
      #1;
      chk("nr14_idle", 128'({bz14, ir14}), 128'(2'b01));

      // randomized traffic against the cycle-count model
      @(negedge clk);
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_busy = 1'b0;
      m_cnt = 0;
      m_rc_known = 1'b1;
      for (int n = 0; n < 600; n++) begin
         logic        iv, ordy, ab;
         logic [18:0] exp, msk;
         @(negedge clk);
         iv   = ($urandom_range(0, 1) == 1);
         ordy = ($urandom_range(0, 2) == 0);
         ab   = 1'b0;
`ifdef AES_ABORT_EN
         ab    = ($urandom_range(0, 15) == 0);
         abort = ab;
`endif
         in_valid  = iv;
         out_ready = ordy;
         #1;
         msk = '1;
         if (!m_busy) begin
            exp = pack(1'b1, 1'b0, iv, iv, 1'b0, 1'b0, 4'd0, 8'h01);
            if (!m_rc_known) msk = ~19'h000ff;
         end else if (m_cnt < NR) begin
            exp = pack(1'b0, 1'b0, !ab, 1'b0, (m_cnt == NR - 1), 1'b1, 4'(m_cnt + 1), rc_pow[m_cnt]);
         end else begin
            exp = pack(1'b0, !ab, 1'b0, 1'b0, 1'b0, 1'b1, 4'(NR), rc_pow[NR-1]);
         end
         chk($sformatf("rand%0d", n), 128'(dut_vec() & msk), 128'(exp & msk));
         if (!m_busy) begin
            if (iv) begin
               m_busy = 1'b1;
               m_cnt  = 0;
            end
         end else if (ab) begin
            m_busy     = 1'b0;
            m_rc_known = 1'b1;
         end else if (m_cnt < NR) begin
            m_cnt++;
         end else if (ordy) begin
            m_busy     = 1'b0;
            m_rc_known = 1'b0;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
